// File: rtl/apb_fifo_slave_if.sv
// APB3 bus bundle between the AHB-to-APB bridge (master) and the FIFO completer (slave).
interface apb_fifo_slave_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_fifo_slave.sv
// APB3 completer wrapping one FIFO behind DATA/STATUS/CTRL registers with wait states and a level IRQ.
// Optional feature: define APB_FIFO_SLVERR_EN to report PSLVERR on full push, empty pop, STATUS write and unmapped access.
module apb_fifo_slave #(
  parameter int DEPTH       = 16,
  parameter int DW          = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic            PCLK,
  input  logic            PRESET,
  apb_fifo_slave_if.slave apb,
  output logic            IRQ
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [3:0]    WS_LOAD  = 4'(WAIT_STATES);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_CTRL   = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [3:0]      wait_cnt_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            ctrl_en_r;
  logic [31:0]     prdata_r;
  logic            pready_r;
  logic            pslverr_r;
  logic            irq_r;
  logic [DW-1:0]   mem_r [DEPTH];

  logic            empty_s;
  logic            full_s;
  logic [31:0]     head_s;
  logic [31:0]     status_s;
  logic [31:0]     rdata_s;
  logic            err_s;
  logic            slverr_s;
  logic            push_s;
  logic            pop_s;
  logic            ctrl_wr_s;
  logic            enter_done_s;
  logic            commit_s;
  logic            unused_s;

  assign unused_s = ^{apb.PADDR[31:8], apb.PWDATA};

  // Register decode: what this access would return and which side effect it would commit
  always_comb begin
    empty_s   = (count_r == {CW{1'b0}});
    full_s    = (count_r == DEPTH_C);
    head_s    = 32'd0;
    head_s[DW-1:0] = mem_r[rd_ptr_r];
    status_s  = 32'd0;
    status_s[0]      = empty_s;
    status_s[1]      = full_s;
    status_s[2 +: CW] = count_r;
    rdata_s   = 32'd0;
    err_s     = 1'b0;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    ctrl_wr_s = 1'b0;
    if (apb.PADDR[7:0] == ADDR_DATA) begin
      if (apb.PWRITE) begin
        if (full_s) begin
          err_s = 1'b1;
        end else begin
          push_s = 1'b1;
        end
      end else begin
        if (empty_s) begin
          err_s = 1'b1;
        end else begin
          pop_s   = 1'b1;
          rdata_s = head_s;
        end
      end
    end else if (apb.PADDR[7:0] == ADDR_STATUS) begin
      if (apb.PWRITE) begin
        err_s = 1'b1;
      end else begin
        rdata_s = status_s;
      end
    end else if (apb.PADDR[7:0] == ADDR_CTRL) begin
      if (apb.PWRITE) begin
        ctrl_wr_s = 1'b1;
      end else begin
        rdata_s = {31'd0, ctrl_en_r};
      end
    end else begin
      err_s = 1'b1;
    end
`ifdef APB_FIFO_SLVERR_EN
    slverr_s = err_s;
`else
    slverr_s = 1'b0;
`endif
  end

  // Transfer sequencing: when the response is launched and when the side effect lands
  always_comb begin
    enter_done_s = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (apb.PSEL && !apb.PENABLE && (WAIT_STATES == 0)) begin
          enter_done_s = 1'b1;
        end else begin
          enter_done_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (apb.PSEL && apb.PENABLE && (wait_cnt_r <= 4'd1)) begin
          enter_done_s = 1'b1;
        end else begin
          enter_done_s = 1'b0;
        end
      end
      ST_DONE: begin
        commit_s = apb.PSEL;
      end
      default: begin
        enter_done_s = 1'b0;
        commit_s     = 1'b0;
      end
    endcase
  end

  // Transfer FSM, registered APB response, FIFO bookkeeping and IRQ
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      ctrl_en_r  <= 1'b0;
      prdata_r   <= 32'd0;
      pready_r   <= 1'b0;
      pslverr_r  <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      irq_r <= ctrl_en_r & ~empty_s;

      // The response is only ever presented for the single DONE cycle
      if (enter_done_s) begin
        pready_r  <= 1'b1;
        prdata_r  <= rdata_s;
        pslverr_r <= slverr_s;
      end else begin
        pready_r  <= 1'b0;
        prdata_r  <= 32'd0;
        pslverr_r <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (apb.PSEL && !apb.PENABLE) begin
            wait_cnt_r <= WS_LOAD;
            state_r    <= (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!apb.PSEL) begin
            state_r <= ST_IDLE;
          end else if (enter_done_s) begin
            wait_cnt_r <= 4'd0;
            state_r    <= ST_DONE;
          end else if (apb.PENABLE) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      if (commit_s) begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
          count_r  <= count_r + CNT_ONE;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
          count_r  <= count_r - CNT_ONE;
        end
        if (ctrl_wr_s) begin
          ctrl_en_r <= apb.PWDATA[0];
          if (apb.PWDATA[1]) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
          end
        end
      end
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset is needed
  always_ff @(posedge PCLK) begin
    if (commit_s && push_s) begin
      mem_r[wr_ptr_r] <= apb.PWDATA[DW-1:0];
    end
  end

  assign apb.PRDATA  = prdata_r;
  assign apb.PREADY  = pready_r;
  assign apb.PSLVERR = pslverr_r;
  assign IRQ         = irq_r;

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Randomised scoreboard bench for apb_fifo_slave; expectations come from a queue-based register model.
module tb_apb_fifo_slave;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int WS    = 1;
  localparam logic [31:0] DMASK = 32'h0000_00FF;
`ifdef APB_FIFO_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        irq;
    int          done_cyc;
  } exp_t;

  logic PCLK = 1'b0;
  logic PRESET;
  logic IRQ;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  bit   mon_en = 1'b0;
  int   irq_cnt = 0;
  logic irq_exp = 1'b0;

  exp_t exp_q[$];
  int   model_q[$];
  bit   model_en = 1'b0;

  apb_fifo_slave_if bus();

  apb_fifo_slave #(.DEPTH(DEPTH), .DW(DW), .WAIT_STATES(WS)) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .apb   (bus),
    .IRQ   (IRQ)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Register-level behaviour of the slave, one call per completed transfer
  function automatic void model(input bit wr, input logic [31:0] addr, input logic [31:0] wd, output exp_t e);
    int n;
    e.rdata = 32'd0;
    e.err   = 1'b0;
    n = model_q.size();
    case (addr[7:0])
      8'h00: begin
        if (wr) begin
          if (n == DEPTH) e.err = 1'b1;
          else model_q.push_back(int'(wd & DMASK));
        end else begin
          if (n == 0) e.err = 1'b1;
          else e.rdata = 32'(model_q.pop_front());
        end
      end
      8'h04: begin
        if (wr) e.err = 1'b1;
        else e.rdata = 32'(n * 4 + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0));
      end
      8'h08: begin
        if (wr) begin
          model_en = wd[0];
          if (wd[1]) model_q.delete();
        end else begin
          e.rdata = {31'd0, model_en};
        end
      end
      default: e.err = 1'b1;
    endcase
    if (!SLVERR_EN) e.err = 1'b0;
    e.irq = model_en && (model_q.size() != 0);
    e.done_cyc = 0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    bit   seen;
    model(wr, addr, wd, e);
    e.done_cyc = cyc + 1 + WS;
    exp_q.push_back(e);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wd;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge PCLK);
      if (bus.PREADY === 1'b1) seen = 1'b1;
    end
    chk("pready_within_budget", {31'd0, seen}, 32'd1);
    if (!seen) exp_q.delete();
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  // Setup phase followed by deselect while the slave is still waiting
  task automatic xfer_abort(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wd;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0;
    idle(2);
  endtask

  // Monitor: compare every completion against the scoreboard, and idle cycles against zero
  initial begin : monitor
    exp_t e;
    wait (mon_en);
    forever begin
      @(negedge PCLK);
      if (irq_cnt > 0) begin
        irq_cnt--;
        if (irq_cnt == 0) chk("irq_after_commit", {31'd0, IRQ}, {31'd0, irq_exp});
      end
      if (bus.PREADY === 1'b1) begin
        chk("ready_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("prdata", bus.PRDATA, e.rdata);
          chk("pslverr", {31'd0, bus.PSLVERR}, {31'd0, e.err});
          chk("latency", 32'(cyc), 32'(e.done_cyc));
          irq_cnt = 2;
          irq_exp = e.irq;
        end
      end else begin
        chk("prdata_idle", bus.PRDATA, 32'd0);
        chk("pslverr_idle", {31'd0, bus.PSLVERR}, 32'd0);
      end
    end
  end

  initial begin : stimulus
    logic [31:0] addr;
    logic [31:0] wd;
    bit          wr;
    int          r;
    PRESET = 1'b1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 32'd0; bus.PWDATA = 32'd0;
    repeat (3) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    chk("reset_pready", {31'd0, bus.PREADY}, 32'd0);
    chk("reset_prdata", bus.PRDATA, 32'd0);
    chk("reset_pslverr", {31'd0, bus.PSLVERR}, 32'd0);
    chk("reset_irq", {31'd0, IRQ}, 32'd0);
    mon_en = 1'b1;
    idle(1);

    xfer(1'b0, 32'h04, 32'd0);
    xfer(1'b1, 32'h08, 32'h1);
    xfer(1'b1, 32'h00, 32'hA5);
    xfer(1'b0, 32'h04, 32'd0);
    xfer(1'b0, 32'h00, 32'd0);
    idle(3);

    for (int i = 0; i < DEPTH; i++) xfer(1'b1, 32'h00, 32'(i));
    xfer(1'b0, 32'h04, 32'd0);
    xfer(1'b1, 32'h00, 32'h5A);
    xfer(1'b0, 32'h04, 32'd0);
    for (int i = 0; i < DEPTH; i++) xfer(1'b0, 32'h00, 32'd0);

    xfer(1'b0, 32'h00, 32'd0);
    xfer(1'b0, 32'h0C, 32'd0);
    xfer(1'b1, 32'h04, 32'hFF);
    xfer(1'b1, 32'h0C, 32'h12);

    xfer(1'b1, 32'h08, 32'h0);
    for (int i = 0; i < 3; i++) xfer(1'b1, 32'h00, 32'(8'h30 + i));
    xfer(1'b1, 32'h08, 32'h3);
    xfer(1'b0, 32'h04, 32'd0);
    xfer(1'b0, 32'h08, 32'd0);
    idle(3);
    chk("irq_after_flush", {31'd0, IRQ}, 32'd0);

    xfer_abort(1'b1, 32'h00, 32'h99);
    xfer(1'b0, 32'h04, 32'd0);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      addr = 32'h00 | ({$urandom} & 32'hFFFF_FF00);
      else if (r <= 6) addr = 32'h04;
      else if (r == 7) addr = 32'h08;
      else if (r == 8) addr = 32'h0C;
      else             addr = $urandom;
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (addr[7:0] == 8'h08) wd[1] = ($urandom_range(0, 7) == 0);
      xfer(wr, addr, wd);
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
    end

    xfer(1'b1, 32'h08, 32'h3);
    xfer(1'b1, 32'h08, 32'h1);
    xfer(1'b1, 32'h00, 32'h11);
    xfer(1'b1, 32'h00, 32'h22);
    idle(4);
    chk("irq_before_reset", {31'd0, IRQ}, 32'd1);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'h00; bus.PWDATA = 32'h33;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    #2;
    PRESET = 1'b1;
    #1;
    chk("midreset_pready", {31'd0, bus.PREADY}, 32'd0);
    chk("midreset_irq", {31'd0, IRQ}, 32'd0);
    chk("midreset_prdata", bus.PRDATA, 32'd0);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    model_q.delete();
    model_en = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    idle(1);
    xfer(1'b0, 32'h04, 32'd0);
    xfer(1'b0, 32'h00, 32'd0);
    xfer(1'b0, 32'h08, 32'd0);

    idle(4);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
